fpga_host_nbf_tx_arbiter: RTL and testbench
===========================================

Name: fpga_host_nbf_tx_arbiter

Overview:
Shares one UART transmitter between several NBF packet sources inside the FPGA host, e.g. the host loopback/response path and the error/status reporter. Each packet is granted atomically in round-robin order. The granted packet is serialized least-significant byte first into the ready/valid byte interface of uart_tx. The block sits between the host's NBF output buffers and uart_tx.

Parameters:
num_req_p, 2, number of requesters (2..8)
nbf_addr_width_p, 40, NBF address field width
nbf_data_width_p, 64, NBF data field width
uart_data_bits_p, 8, bits per UART character
nbf_width_lp, 8+nbf_addr_width_p+nbf_data_width_p (112), derived packet width; must be a multiple of uart_data_bits_p
nbf_chars_lp, nbf_width_lp/uart_data_bits_p (14), derived characters per packet
req_id_width_lp, max(1,$clog2(num_req_p)), derived grant-id width

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
nbf_v_i  in  num_req_p  per-requester packet valid
nbf_i  in  num_req_p*nbf_width_lp  packets; requester r occupies [r*nbf_width_lp +: nbf_width_lp]
nbf_ready_and_o  out  num_req_p  per-requester accept
tx_v_o  out  1  character valid to uart_tx.tx_v_i
tx_o  out  uart_data_bits_p  character to uart_tx.tx_i
tx_ready_and_i  in  1  from uart_tx.tx_ready_and_o
busy_o  out  1  packet in flight
grant_id_o  out  req_id_width_lp  requester owning the current or most recent packet

Behaviour:
- One clock, clk_i. reset_i is asynchronous and active-high.
- Reset values: state=e_idle, char count=0, packet register=0, last-grant pointer=num_req_p-1 (requester 0 has first priority), tx_v_o=0, tx_o=0, busy_o=0, grant_id_o=0, nbf_ready_and_o=0.
- FSM states:
  - e_idle:
    - Round-robin search of nbf_v_i, starting at (last+1) mod num_req_p.
    - If a winner g exists: nbf_ready_and_o = one-hot(g) in the same cycle. nbf_ready_and_o may depend combinationally on nbf_v_i; requesters must not make v depend on ready.
    - On that handshake: capture nbf_i slice g, set grant_id_o=g, last=g, count=0, then go to e_send.
    - If no winner: stay in e_idle, all ready outputs 0.
  - e_send:
    - tx_v_o=1, busy_o=1, tx_o = pkt[count*uart_data_bits_p +: uart_data_bits_p].
    - nbf_ready_and_o=0 for all requesters.
    - On tx_v_o & tx_ready_and_i: count++.
    - On a handshake with count==nbf_chars_lp-1: go to e_idle, count=0.
- tx_o is 0 whenever tx_v_o=0.
- Latency:
  - Packet accepted in cycle N; the first character is presented in cycle N+1.
  - Exactly nbf_chars_lp character handshakes per packet.
  - One e_idle cycle between consecutive packets, so the next accept is earliest the cycle after the last character handshake.
- Stall: while tx_ready_and_i=0, tx_v_o stays 1 and tx_o stays stable. No character is skipped or duplicated.
- Fairness: the pointer advances only on an accepted packet. With all requesters continuously valid, grants cycle 0,1,...,num_req_p-1,0.
- Valid dropping in e_send has no effect; the packet is already captured.
- Reset mid-packet:
  - Asynchronously forces all reset values; the partial packet is discarded and tx_v_o drops immediately.
  - The interrupted requester is not re-offered the packet; resending it is the source's responsibility.
- The packet register is loaded only on the accept handshake.

Test Plan:
1. Requester 0 only, nbf_i[111:0]=112'h0102030405060708090A0B0C0D0E, tx_ready_and_i=1 -> accept in cycle N; tx_o=0x0E,0x0D,...,0x01 in cycles N+1..N+14; busy_o falls at N+15.
2. Both requesters continuously valid, packets 0xAA..AA and 0x55..55 -> grant_id_o sequence 0,1,0,1; 14 characters per packet with no interleaving inside a packet.
3. Single packet; tx_ready_and_i low for 100 cycles while character 5 is presented -> tx_v_o=1 and tx_o=0x09 held for all 100 cycles; remaining characters 0x08..0x01 follow with no loss.
4. Requester 1 valid, requester 0 idle at reset -> requester 1 granted; nbf_ready_and_o[0] never asserts; pointer becomes 1, so a later simultaneous request grants 0 first.
5. reset_i pulsed between clock edges after character 7 -> tx_v_o=0, busy_o=0 before the next edge. After release, requester 0's new packet starts at character 0.
6. Full loop: arbiter driving uart_tx at clk_per_bit 16, decoded by uart_rx -> received 14 bytes equal the sent packet, rx_error_o=0.

Source files
------------

// File: rtl/fpga_host_nbf_tx_arbiter.sv
// Round-robin arbiter that grants whole NBF packets to one UART transmitter and
// serializes the granted packet least-significant character first.
module fpga_host_nbf_tx_arbiter #(
  parameter int num_req_p        = 2,
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int uart_data_bits_p = 8,
  localparam int nbf_width_lp    = 8 + nbf_addr_width_p + nbf_data_width_p,
  localparam int nbf_chars_lp    = nbf_width_lp / uart_data_bits_p,
  localparam int req_id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              nbf_v_i,
  input  logic [num_req_p*nbf_width_lp-1:0] nbf_i,
  output logic [num_req_p-1:0]              nbf_ready_and_o,
  output logic                              tx_v_o,
  output logic [uart_data_bits_p-1:0]       tx_o,
  input  logic                              tx_ready_and_i,
  output logic                              busy_o,
  output logic [req_id_width_lp-1:0]        grant_id_o
);

  localparam int cnt_width_lp = (nbf_chars_lp > 1) ? $clog2(nbf_chars_lp) : 1;

  // Valid/ready: a transfer happens on any rising clk_i edge where both valid
  // and ready are high; ready toward requesters may depend on their valid.
  typedef enum logic {e_idle, e_send} state_e;

  state_e                     state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [nbf_width_lp-1:0]    pkt_q, pkt_d;
  logic [req_id_width_lp-1:0] last_q, last_d;
  logic [req_id_width_lp-1:0] grant_q, grant_d;

  logic                       found;
  logic [req_id_width_lp-1:0] win;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = int'(last_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && nbf_v_i[idx]) begin
        found = 1'b1;
        win   = req_id_width_lp'(idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pkt_d           = pkt_q;
    last_d          = last_q;
    grant_d         = grant_q;
    nbf_ready_and_o = '0;
    tx_v_o          = 1'b0;
    tx_o            = '0;
    busy_o          = 1'b0;
    case (state_q)
      e_idle: begin
        if (found) begin
          nbf_ready_and_o[win] = 1'b1;
          pkt_d                = nbf_i[win*nbf_width_lp +: nbf_width_lp];
          grant_d              = win;
          last_d               = win;
          cnt_d                = '0;
          state_d              = e_send;
        end
      end
      e_send: begin
        tx_v_o = 1'b1;
        busy_o = 1'b1;
        tx_o   = pkt_q[cnt_q*uart_data_bits_p +: uart_data_bits_p];
        if (tx_ready_and_i) begin
          if (cnt_q == cnt_width_lp'(nbf_chars_lp - 1)) begin
            cnt_d   = '0;
            state_d = e_idle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      pkt_q   <= '0;
      last_q  <= req_id_width_lp'(num_req_p - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_fpga_host_nbf_tx_arbiter.sv
// Self-checking bench for fpga_host_nbf_tx_arbiter: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_fpga_host_nbf_tx_arbiter;
  localparam int NR = 2;
  localparam int PW = 112;
  localparam int BW = 8;
  localparam int NC = PW / BW;
  localparam int RW = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     nbf_v;
  logic [NR*PW-1:0]  nbf;
  logic [NR-1:0]     ready;
  logic              tx_v;
  logic [BW-1:0]     tx;
  logic              tx_ready;
  logic              busy;
  logic [RW-1:0]     grant;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  fpga_host_nbf_tx_arbiter dut (
    .clk_i(clk), .reset_i(rst), .nbf_v_i(nbf_v), .nbf_i(nbf),
    .nbf_ready_and_o(ready), .tx_v_o(tx_v), .tx_o(tx), .tx_ready_and_i(tx_ready),
    .busy_o(busy), .grant_id_o(grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; nbf_v = '0; nbf = '0; tx_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; nbf_v = '0; nbf = '0; tx_ready = 1'b1;
    #3;
    checks++; if (tx_v !== 1'b0) begin failures++; $display("FAIL reset_tx_v got=%0h exp=0", tx_v); end
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL reset_tx got=%0h exp=0", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0h exp=0", grant); end
    checks++; if (ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%0h exp=0", ready); end
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_v !== 1'b0) begin failures++; $display("FAIL post_reset_tx_v got=%0h exp=0", tx_v); end
    tick;
  endtask

  task automatic test_single;
    logic [PW-1:0] pkt;
    pkt = 112'h0102030405060708090A0B0C0D0E;
    do_reset;
    nbf[PW-1:0] = pkt; nbf_v = 2'b01; tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%0h exp=1", ready); end
    tick;
    nbf_v = '0;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      checks++; if (tx_v !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_valid k=%0d got=%0h/%0h exp=1/1", k, tx_v, busy); end
      checks++; if (tx !== pkt[k*BW +: BW]) begin failures++; $display("FAIL single_char k=%0d got=%0h exp=%0h", k, tx, pkt[k*BW +: BW]); end
      tick;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_v !== 1'b0) begin failures++; $display("FAIL single_done got=%0h/%0h exp=0/0", busy, tx_v); end
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL single_grant got=%0h exp=0", grant); end
  endtask

  task automatic test_stall;
    logic [PW-1:0] pkt;
    pkt = 112'h0102030405060708090A0B0C0D0E;
    do_reset;
    nbf[PW-1:0] = pkt; nbf_v = 2'b01; tx_ready = 1'b1;
    tick;
    nbf_v = '0;
    for (int k = 0; k < NC; k++) begin
      if (k == 5) begin
        for (int s = 0; s < 100; s++) begin
          tx_ready = 1'b0;
          @(negedge clk);
          checks++; if (tx_v !== 1'b1 || tx !== 8'h09) begin failures++; $display("FAIL stall_hold s=%0d got=%0h/%0h exp=1/09", s, tx_v, tx); end
          tick;
        end
        tx_ready = 1'b1;
      end
      @(negedge clk);
      checks++; if (tx !== pkt[k*BW +: BW]) begin failures++; $display("FAIL stall_char k=%0d got=%0h exp=%0h", k, tx, pkt[k*BW +: BW]); end
      tick;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_done got=%0h exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [BW-1:0] b;
    do_reset;
    nbf[PW-1:0] = {NC{8'hAA}}; nbf[PW +: PW] = {NC{8'h55}};
    nbf_v = 2'b11; tx_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      checks++; if (ready !== 2'(1 << (p % 2))) begin failures++; $display("FAIL b2b_ready p=%0d got=%0h exp=%0h", p, ready, 2'(1 << (p % 2))); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap p=%0d got=%0h exp=0", p, busy); end
      tick;
      b = (p % 2 == 1) ? 8'h55 : 8'hAA;
      for (int k = 0; k < NC; k++) begin
        @(negedge clk);
        checks++; if (tx !== b || ready !== 2'b00) begin failures++; $display("FAIL b2b_char p=%0d k=%0d got=%0h/%0h exp=%0h/0", p, k, tx, ready, b); end
        checks++; if (grant !== RW'(p % 2)) begin failures++; $display("FAIL b2b_grant p=%0d got=%0h exp=%0h", p, grant, p % 2); end
        tick;
      end
    end
    nbf_v = '0;
  endtask

  task automatic test_fairness;
    logic [PW-1:0] pkt;
    pkt = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
    do_reset;
    nbf[PW +: PW] = pkt; nbf_v = 2'b10; tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 2'b10) begin failures++; $display("FAIL fair_first got=%0h exp=2", ready); end
    tick;
    nbf_v = 2'b01;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL fair_send_ready k=%0d got=%0h exp=0", k, ready); end
      checks++; if (tx !== pkt[k*BW +: BW]) begin failures++; $display("FAIL fair_char k=%0d got=%0h exp=%0h", k, tx, pkt[k*BW +: BW]); end
      tick;
    end
    nbf_v = 2'b11;
    @(negedge clk);
    checks++; if (ready !== 2'b01) begin failures++; $display("FAIL fair_rotate got=%0h exp=1", ready); end
    checks++; if (grant !== 1'b1) begin failures++; $display("FAIL fair_grant1 got=%0h exp=1", grant); end
    tick;
    nbf_v = '0;
    repeat (NC) tick;
    @(negedge clk);
    checks++; if (grant !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fair_grant0 got=%0h/%0h exp=0/0", grant, busy); end
  endtask

  task automatic test_async_reset;
    logic [PW-1:0] a, b;
    a = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
    b = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
    do_reset;
    nbf[PW-1:0] = a; nbf_v = 2'b01; tx_ready = 1'b1;
    tick;
    nbf_v = '0;
    repeat (7) tick;
    @(negedge clk);
    checks++; if (tx !== a[7*BW +: BW]) begin failures++; $display("FAIL arst_char7 got=%0h exp=%0h", tx, a[7*BW +: BW]); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_v !== 1'b0 || busy !== 1'b0 || tx !== 8'h00) begin failures++; $display("FAIL arst_drop got=%0h/%0h/%0h exp=0/0/0", tx_v, busy, tx); end
    #1 rst = 1'b0;
    nbf[PW-1:0] = b; nbf_v = 2'b01;
    #1;
    checks++; if (ready !== 2'b01) begin failures++; $display("FAIL arst_reaccept got=%0h exp=1", ready); end
    tick;
    nbf_v = '0;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      checks++; if (tx_v !== 1'b1 || tx !== b[k*BW +: BW]) begin failures++; $display("FAIL arst_newpkt k=%0d got=%0h/%0h exp=1/%0h", k, tx_v, tx, b[k*BW +: BW]); end
      tick;
    end
  endtask

  // Reference: an idle arbiter picks the first valid requester after the last
  // winner; an accepted packet becomes NC queued characters drained in order.
  task automatic test_random;
    bit            m_busy;
    int            m_last;
    logic [RW-1:0] m_grant;
    logic [NR-1:0] exp_ready;
    logic [PW-1:0] s;
    int            w;
    do_reset;
    m_busy = 1'b0; m_last = NR - 1; m_grant = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        nbf_v[r] = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 3) == 0) nbf[r*PW +: PW] = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      checks++; if (grant !== m_grant) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%0h exp=%0h", cyc, grant, m_grant); end
      if (!m_busy) begin
        w = -1;
        for (int i = 1; i <= NR; i++) begin
          if (w < 0 && nbf_v[(m_last + i) % NR]) w = (m_last + i) % NR;
        end
        exp_ready = (w >= 0) ? NR'(1 << w) : '0;
        checks++; if (ready !== exp_ready || tx_v !== 1'b0 || busy !== 1'b0 || tx !== 8'h00) begin failures++; $display("FAIL rnd_idle cyc=%0d got=%0h/%0h/%0h/%0h exp=%0h/0/0/0", cyc, ready, tx_v, busy, tx, exp_ready); end
        if (w >= 0) begin
          s = nbf[w*PW +: PW];
          for (int k = 0; k < NC; k++) exp_q.push_back(s[k*BW +: BW]);
          m_last = w; m_grant = RW'(w); m_busy = 1'b1;
        end
      end else begin
        checks++; if (tx_v !== 1'b1 || busy !== 1'b1 || ready !== '0 || tx !== exp_q[0]) begin failures++; $display("FAIL rnd_send cyc=%0d got=%0h/%0h/%0h/%0h exp=1/1/0/%0h", cyc, tx_v, busy, ready, tx, exp_q[0]); end
        if (tx_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_busy = 1'b0;
        end
      end
      tick;
    end
    nbf_v = '0;
  endtask

  initial begin
    rst = 1'b1; nbf_v = '0; nbf = '0; tx_ready = 1'b0;
    test_reset;
    test_single;
    test_stall;
    test_back_to_back;
    test_fairness;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
